// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM-stage load/store port.
// Optional DMEM_POSTED_WR_EN: writes accepted in IDLE complete without stalling.
module dmem_responder #(
    parameter int unsigned ARQ              = 16,
    parameter int unsigned MEMORY_ADDR_SIZE = 13,
    parameter int unsigned DEPTH            = 4096,
    parameter int unsigned LATENCY          = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_mem_en,
    input  logic                        wr_mem_en,
    input  logic [MEMORY_ADDR_SIZE-1:0] addr,
    input  logic [ARQ-1:0]              wdata,
    output logic                        stall,
    output logic                        rvalid,
    output logic [ARQ-1:0]              rdata,
    output logic                        err
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                        wr;
        logic                        conflict;
        logic [MEMORY_ADDR_SIZE-1:0] addr;
        logic [ARQ-1:0]              wdata;
    } req_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_t             held;
    req_t             in_req;
    req_t             cur;
    logic [ARQ-1:0]   mem [DEPTH];

    logic             req_now;
    logic             posted_wr;
    logic             finish;
    logic             complete;
    logic             in_range;
    logic             commit;
    logic [IDX_W-1:0] idx;

`ifdef DMEM_POSTED_WR_EN
    assign posted_wr = (state == IDLE) && wr_mem_en;
`else
    assign posted_wr = 1'b0;
`endif

    // In IDLE the live request is the operand (LATENCY=1 or posted); otherwise the latched one.
    always_comb begin
        in_req.wr       = wr_mem_en;
        in_req.conflict = rd_mem_en & wr_mem_en;
        in_req.addr     = addr;
        in_req.wdata    = wdata;
        req_now         = rd_mem_en | wr_mem_en;
        cur             = (state == IDLE) ? in_req : held;
        in_range        = 32'(cur.addr) < DEPTH;
        idx             = cur.addr[IDX_W-1:0];
        finish          = ((state == IDLE) && req_now && !posted_wr && (LATENCY == 1))
                        || ((state == WAIT) && (cnt == CNT_W'(1)));
        complete        = finish | posted_wr;
        commit          = rst && complete && cur.wr && in_range;
        stall           = rst && (((state == IDLE) && req_now && !posted_wr) || (state == WAIT));
    end

    // Storage is never reset; a write only lands on its completion edge.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx] <= cur.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            held   <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (complete) begin
                err <= cur.conflict | ~in_range;
                if (!cur.wr) begin
                    rvalid <= 1'b1;
                    rdata  <= in_range ? mem[idx] : '0;
                end
            end
            case (state)
                IDLE: begin
                    if (req_now && !posted_wr) begin
                        held  <= in_req;
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
